// File: rtl/grid_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : grid_write_arbiter
// Purpose  : Shares the object_grid write port among player requesters with
//            round-robin grant and a per-frame cell lock table.
// Option   : GRID_ARB_LOCAL_PRIORITY_EN - local player wins whenever eligible
// Revision : 1.0 - initial release
// ============================================================================
module grid_write_arbiter #(
    parameter int N_REQ      = 4,
    parameter int GRID_W     = 13,
    parameter int GRID_H     = 8,
    parameter int OBJ_W      = 4,
    parameter int LOCK_DEPTH = 4,
    parameter int PLAY_STATE = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic [2:0]             game_state,
    input  logic [1:0]             num_players,
    input  logic [1:0]             local_player_ID,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*4-1:0]     req_x,
    input  logic [N_REQ*3-1:0]     req_y,
    input  logic [N_REQ*OBJ_W-1:0] req_obj,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       nack,
    output logic                   wr_en,
    output logic [3:0]             wr_x,
    output logic [2:0]             wr_y,
    output logic [OBJ_W-1:0]       wr_data,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic [2:0]             writes_this_frame
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [1:0]       r_rr;
    logic [N_REQ-1:0] r_mask;
    logic [3:0]       r_x;
    logic [2:0]       r_y;
    logic [OBJ_W-1:0] r_obj;
    logic [1:0]       r_gid;
    logic             r_local_win;
    logic [3:0]       r_lock_x [LOCK_DEPTH];
    logic [2:0]       r_lock_y [LOCK_DEPTH];
    logic [2:0]       r_count;
    logic [N_REQ-1:0] r_ack;
    logic [N_REQ-1:0] r_nack;
    logic             r_wr;

    logic             w_play;
    logic [N_REQ-1:0] w_active;
    logic [N_REQ-1:0] w_elig;
    logic [2:0]       w_pick;
    logic             w_found;
    logic [1:0]       w_win;
    logic             w_local_win;
    logic [3:0]       w_sel_x;
    logic [2:0]       w_sel_y;
    logic [OBJ_W-1:0] w_sel_obj;
    logic             w_hit;
    logic             w_full;
    logic             w_oor;
    logic             w_grant_ok;
    logic [N_REQ-1:0] w_ack_d;
    logic [N_REQ-1:0] w_nack_d;
    logic             w_wr_d;

    // Returns {found, index} of the first set bit at or after start, wrapping.
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] elig,
                                           input logic [1:0]       start);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = 2'((int'(start) + k) % N_REQ);
            if (elig[idx]) pick = {1'b1, idx};
        end
        return pick;
    endfunction

    assign w_play = (game_state == 3'(PLAY_STATE));

    always_comb begin
        w_active = '0;
        for (int i = 0; i < N_REQ; i++) w_active[i] = (i <= int'(num_players));
    end

    assign w_elig = req & w_active & ~r_mask;

`ifdef GRID_ARB_LOCAL_PRIORITY_EN
    // The local player bypasses the rotation; the others rotate among themselves.
    always_comb begin
        w_pick      = rr_pick(w_elig & ~(N_REQ'(1) << local_player_ID), r_rr);
        w_local_win = 1'b0;
        if (w_elig[local_player_ID]) begin
            w_pick      = {1'b1, local_player_ID};
            w_local_win = 1'b1;
        end
    end
`else
    logic w_unused_local;
    assign w_unused_local = ^local_player_ID;

    always_comb begin
        w_pick      = rr_pick(w_elig, r_rr);
        w_local_win = 1'b0;
    end
`endif

    assign w_found = w_pick[2];
    assign w_win   = w_pick[1:0];

    always_comb begin
        w_sel_x   = '0;
        w_sel_y   = '0;
        w_sel_obj = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == 2'(i)) begin
                w_sel_x   = req_x[i*4 +: 4];
                w_sel_y   = req_y[i*3 +: 3];
                w_sel_obj = req_obj[i*OBJ_W +: OBJ_W];
            end
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < LOCK_DEPTH; k++) begin
            if ((3'(k) < r_count) && (r_lock_x[k] == r_x) && (r_lock_y[k] == r_y))
                w_hit = 1'b1;
        end
    end

    assign w_full     = (r_count >= 3'(LOCK_DEPTH));
    assign w_oor      = ({28'd0, r_x} >= 32'(GRID_W)) || ({29'd0, r_y} >= 32'(GRID_H));
    assign w_grant_ok = !w_oor && !w_hit && !w_full;

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_play && w_found) w_next_state = ST_CHECK;
            ST_CHECK: w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Response pulses are decided in CHECK and registered so they appear in RESP.
    always_comb begin
        w_ack_d  = '0;
        w_nack_d = '0;
        w_wr_d   = 1'b0;
        if (r_state == ST_CHECK) begin
            if (w_grant_ok) begin
                w_ack_d = N_REQ'(1) << r_gid;
                w_wr_d  = 1'b1;
            end else begin
                w_nack_d = N_REQ'(1) << r_gid;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ack  <= '0;
            r_nack <= '0;
            r_wr   <= 1'b0;
        end else begin
            r_ack  <= w_ack_d;
            r_nack <= w_nack_d;
            r_wr   <= w_wr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr        <= '0;
            r_mask      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_obj       <= '0;
            r_gid       <= '0;
            r_local_win <= 1'b0;
            r_count     <= '0;
            for (int k = 0; k < LOCK_DEPTH; k++) begin
                r_lock_x[k] <= '0;
                r_lock_y[k] <= '0;
            end
        end else begin
            if (r_state == ST_IDLE && w_play && w_found) begin
                r_x         <= w_sel_x;
                r_y         <= w_sel_y;
                r_obj       <= w_sel_obj;
                r_gid       <= w_win;
                r_local_win <= w_local_win;
            end

            // The winner sits out exactly one IDLE cycle while it drops req.
            if (r_state == ST_RESP) r_mask <= N_REQ'(1) << r_gid;
            else                    r_mask <= '0;

            if (r_state == ST_RESP && !r_local_win)
                r_rr <= 2'((int'(r_gid) + 1) % N_REQ);

            // A frame boundary coinciding with a write clears first, then inserts.
            if (frame_tick)
                r_count <= (r_state == ST_RESP && r_wr) ? 3'd1 : 3'd0;
            else if (r_state == ST_RESP && r_wr)
                r_count <= r_count + 3'd1;

            if (r_state == ST_RESP && r_wr) begin
                for (int k = 0; k < LOCK_DEPTH; k++) begin
                    if ((frame_tick ? 3'd0 : r_count) == 3'(k)) begin
                        r_lock_x[k] <= r_x;
                        r_lock_y[k] <= r_y;
                    end
                end
            end
        end
    end

    assign ack               = r_ack;
    assign nack              = r_nack;
    assign wr_en             = r_wr;
    assign wr_x              = r_x;
    assign wr_y              = r_y;
    assign wr_data           = r_obj;
    assign grant_id          = r_gid;
    assign busy              = (r_state != ST_IDLE);
    assign writes_this_frame = r_count;

endmodule
`default_nettype wire

// File: tb/tb_grid_write_arbiter.sv
`default_nettype none
// Bench for grid_write_arbiter: vector table of single transactions, corner
// sequences, and a randomized run against a transaction-level model.
module tb_grid_write_arbiter;

    localparam int         N        = 4;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd1;

    logic           clock = 1'b0;
    logic           reset;
    logic           frame_tick;
    logic [2:0]     game_state;
    logic [1:0]     num_players;
    logic [1:0]     local_player_ID;
    logic [N-1:0]   req;
    logic [N*4-1:0] req_x;
    logic [N*3-1:0] req_y;
    logic [N*4-1:0] req_obj;
    logic [N-1:0]   ack;
    logic [N-1:0]   nack;
    logic           wr_en;
    logic [3:0]     wr_x;
    logic [2:0]     wr_y;
    logic [3:0]     wr_data;
    logic [1:0]     grant_id;
    logic           busy;
    logic [2:0]     writes_this_frame;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         id;
        logic [3:0] x;
        logic [2:0] y;
        logic [3:0] obj;
        int         ft;     // 0 none, 1 tick before request, 2 tick during RESP
        logic       ok;
        logic [2:0] cnt;
    } vec_t;

    vec_t vt [14];

    logic [3:0] px [N];
    logic [2:0] py [N];
    logic [3:0] po [N];
    bit         pend [N];
    logic [6:0] locks [$];

    grid_write_arbiter dut (
        .clock             (clock),
        .reset             (reset),
        .frame_tick        (frame_tick),
        .game_state        (game_state),
        .num_players       (num_players),
        .local_player_ID   (local_player_ID),
        .req               (req),
        .req_x             (req_x),
        .req_y             (req_y),
        .req_obj           (req_obj),
        .ack               (ack),
        .nack              (nack),
        .wr_en             (wr_en),
        .wr_x              (wr_x),
        .wr_y              (wr_y),
        .wr_data           (wr_data),
        .grant_id          (grant_id),
        .busy              (busy),
        .writes_this_frame (writes_this_frame)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [3:0] x, input logic [2:0] y,
                           input logic [3:0] obj);
        req_x[id*4 +: 4]   = x;
        req_y[id*3 +: 3]   = y;
        req_obj[id*4 +: 4] = obj;
        req[id]            = 1'b1;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit is_locked(input logic [3:0] x, input logic [2:0] y);
        foreach (locks[j]) if (locks[j] == {x, y}) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset           = 1'b1;
        frame_tick      = 1'b0;
        game_state      = ST_PLAY;
        num_players     = 2'd3;
        local_player_ID = 2'd0;
        req             = '0;
        req_x           = '0;
        req_y           = '0;
        req_obj         = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic do_single(input vec_t v);
        int cyc;
        bit seen;
        @(negedge clock);
        if (v.ft == 1) begin
            frame_tick = 1'b1;
            @(negedge clock);
            frame_tick = 1'b0;
        end
        set_req(v.id, v.x, v.y, v.obj);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if ((ack | nack) != '0) seen = 1'b1;
        end
        check("vec_seen", 32'(seen), 32'd1);
        check("vec_latency", cyc, 3);
        check("vec_ack", ack, v.ok ? (4'b1 << v.id) : 4'b0);
        check("vec_nack", nack, v.ok ? 4'b0 : (4'b1 << v.id));
        check("vec_wr_en", wr_en, v.ok);
        check("vec_grant_id", grant_id, v.id);
        if (v.ok) check("vec_wr_bus", {wr_x, wr_y, wr_data}, {v.x, v.y, v.obj});
        req[v.id] = 1'b0;
        if (v.ft == 2) frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        check("vec_wr_drop", {ack, nack, wr_en}, 9'd0);
        check("vec_count", writes_this_frame, v.cnt);
    endtask

    task automatic run_random(input int ncyc);
        int         txn_start;
        int         txn_win;
        int         rr;
        int         mask_id;
        int         w;
        bit         txn_ok;
        bit         txn_local;
        bit         pulse_now;
        bit         pulse_ok;
        bit         found;
        bit         exp_busy;
        logic [3:0] tx;
        logic [2:0] ty;
        logic [3:0] tobj;
        logic [N-1:0] elig;
        logic [N-1:0] exp_ack;
        logic [N-1:0] exp_nack;

        txn_start = -100;
        txn_win   = 0;
        rr        = 0;
        txn_ok    = 1'b0;
        tx        = '0;
        ty        = '0;
        tobj      = '0;
        locks.delete();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        local_player_ID = 2'($urandom_range(0, 3));

        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock);
            pulse_now = (txn_start == c - 2);
            exp_ack   = (pulse_now && txn_ok)  ? (4'b1 << txn_win) : 4'b0;
            exp_nack  = (pulse_now && !txn_ok) ? (4'b1 << txn_win) : 4'b0;
            exp_busy  = (txn_start == c - 1) || (txn_start == c - 2);
            check("rand_status", {ack, nack, wr_en, busy, writes_this_frame},
                  {exp_ack, exp_nack, pulse_now && txn_ok, exp_busy, 3'(locks.size())});
            if (pulse_now) begin
                check("rand_grant_id", grant_id, txn_win);
                if (txn_ok) check("rand_wr_bus", {wr_x, wr_y, wr_data}, {tx, ty, tobj});
                pend[txn_win] = 1'b0;
                req[txn_win]  = 1'b0;
            end
            pulse_ok = pulse_now && txn_ok;

            // Lock decision sees the table as it stands during the check cycle.
            if (txn_start == c - 1)
                txn_ok = (tx < 4'd13) && !is_locked(tx, ty) && (locks.size() < 4);

            frame_tick = ($urandom_range(0, 24) == 0);
            game_state = ($urandom_range(0, 15) == 0) ? ST_PAUSE : ST_PLAY;
            if ($urandom_range(0, 199) == 0) num_players = 2'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    px[i]   = 4'($urandom_range(0, 14));
                    py[i]   = 3'($urandom_range(0, 3));
                    po[i]   = 4'($urandom);
                    set_req(i, px[i], py[i], po[i]);
                end
            end

            if (frame_tick) locks.delete();
            if (pulse_ok) locks.push_back({tx, ty});

            if (txn_start != c - 1 && txn_start != c - 2 && game_state == ST_PLAY) begin
                mask_id   = (txn_start == c - 3) ? txn_win : -1;
                elig      = '0;
                for (int i = 0; i < N; i++)
                    elig[i] = pend[i] && (i <= int'(num_players)) && (i != mask_id);
                found     = 1'b0;
                txn_local = 1'b0;
                w         = 0;
`ifdef GRID_ARB_LOCAL_PRIORITY_EN
                if (elig[local_player_ID]) begin
                    found     = 1'b1;
                    w         = int'(local_player_ID);
                    txn_local = 1'b1;
                end
`endif
                for (int k = 0; k < N && !found; k++) begin
                    if (elig[(rr + k) % N]) begin
                        found = 1'b1;
                        w     = (rr + k) % N;
                    end
                end
                if (found) begin
                    txn_start = c;
                    txn_win   = w;
                    tx        = px[w];
                    ty        = py[w];
                    tobj      = po[w];
                    if (!txn_local) rr = (w + 1) % N;
                end
            end
        end
        @(negedge clock);
        frame_tick = 1'b0;
        req        = '0;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        int np;
        int cnt;
        int gid;
        bit seen;

        vt[0]  = '{0, 4'd3,  3'd2, 4'd5,  0, 1'b1, 3'd1};
        vt[1]  = '{1, 4'd4,  3'd4, 4'd7,  0, 1'b1, 3'd2};
        vt[2]  = '{2, 4'd4,  3'd4, 4'd9,  0, 1'b0, 3'd2};
        vt[3]  = '{0, 4'd13, 3'd1, 4'd3,  0, 1'b0, 3'd2};
        vt[4]  = '{3, 4'd0,  3'd0, 4'd1,  0, 1'b1, 3'd3};
        vt[5]  = '{1, 4'd15, 3'd7, 4'd2,  0, 1'b0, 3'd3};
        vt[6]  = '{2, 4'd12, 3'd7, 4'd15, 0, 1'b1, 3'd4};
        vt[7]  = '{0, 4'd1,  3'd1, 4'd1,  0, 1'b0, 3'd4};
        vt[8]  = '{2, 4'd4,  3'd4, 4'd9,  1, 1'b1, 3'd1};
        vt[9]  = '{3, 4'd4,  3'd4, 4'd1,  0, 1'b0, 3'd1};
        vt[10] = '{0, 4'd2,  3'd3, 4'd4,  0, 1'b1, 3'd2};
        vt[11] = '{1, 4'd6,  3'd6, 4'd6,  2, 1'b1, 3'd1};
        vt[12] = '{2, 4'd2,  3'd3, 4'd4,  0, 1'b1, 3'd2};
        vt[13] = '{3, 4'd6,  3'd6, 4'd1,  0, 1'b0, 3'd2};

        do_reset();
        check("reset_outputs",
              {ack, nack, wr_en, wr_x, wr_y, wr_data, grant_id, busy, writes_this_frame}, 32'd0);

        for (int i = 0; i < 14; i++) do_single(vt[i]);

        // All four requesters at once: strict rotation, one grant every 3 cycles.
        do_reset();
        @(negedge clock);
        for (int i = 0; i < N; i++) set_req(i, 4'(i + 1), 3'(i), 4'(i + 8));
        np = 0;
        for (int c = 2; c <= 16; c++) begin
            @(negedge clock);
            if ((ack | nack) != '0) begin
                check("rr_order", {nack, ack}, {4'b0, 4'b1 << np});
                check("rr_spacing", c, 3 + 3 * np);
                req = req & ~(ack | nack);
                np++;
            end
        end
        check("rr_grant_total", np, 4);
        check("rr_count", writes_this_frame, 3'd4);

        // Requester above num_players is ignored until it becomes active.
        do_reset();
        @(negedge clock);
        num_players = 2'd1;
        set_req(3, 4'd1, 3'd1, 4'd1);
        cnt = 0;
        repeat (30) begin
            @(negedge clock);
            if ((ack | nack) != '0) cnt++;
        end
        check("inactive_ignored", cnt, 0);
        num_players = 2'd3;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clock);
            if (ack[3]) seen = 1'b1;
        end
        check("inactive_then_served", 32'(seen), 32'd1);
        req = '0;

        // Leaving PLAY mid-transaction completes it; PAUSE then freezes grants.
        do_reset();
        @(negedge clock);
        set_req(1, 4'd5, 3'd5, 4'd5);
        @(negedge clock);
        game_state = ST_PAUSE;
        @(negedge clock);
        check("pause_midtxn_ack", ack, 4'b0010);
        req = '0;
        @(negedge clock);
        set_req(0, 4'd7, 3'd7, 4'd3);
        cnt = 0;
        repeat (100) begin
            @(negedge clock);
            if ((ack | nack) != '0) cnt++;
        end
        check("pause_no_grant", cnt, 0);
        game_state = ST_PLAY;
        seen = 1'b0;
        for (int c = 0; c < 3 && !seen; c++) begin
            @(negedge clock);
            if (ack[0]) seen = 1'b1;
        end
        check("play_resume_ack", 32'(seen), 32'd1);
        req = '0;

        // Reset during CHECK aborts the transaction with no pulses.
        do_reset();
        @(negedge clock);
        set_req(0, 4'd2, 3'd2, 4'd2);
        @(negedge clock);
        check("abort_busy", busy, 1'b1);
        reset = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clock);
            if ((ack | nack) != '0 || wr_en || busy) cnt++;
        end
        check("abort_no_pulse", cnt, 0);
        reset = 1'b0;
        req   = '0;

`ifdef GRID_ARB_LOCAL_PRIORITY_EN
        do_reset();
        @(negedge clock);
        local_player_ID = 2'd2;
        for (int i = 0; i < N; i++) set_req(i, 4'(i), 3'(i), 4'(i));
        np = 0;
        for (int c = 0; c < 40 && np < 8; c++) begin
            @(negedge clock);
            if ((ack | nack) != '0) begin
                gid = onehot_idx(ack | nack);
                check("prio_alternate", 32'(gid == 2), 32'(np % 2 == 0));
                np++;
            end
        end
        check("prio_pulses", np, 8);
        req = '0;
`endif

        do_reset();
        run_random(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
